cache_refill_ctrl: RTL
======================

Name: cache_refill_ctrl

Overview:
- Miss-handling FSM for the set-associative caches; sits directly downstream of the replacement-way generator.
- On a lookup miss it latches the one-hot victim way from that generator and pulses its advance enable.
- If the victim is dirty, it writes the victim back; it then fetches the missing line from memory and writes it into the victim way's data/tag arrays.
- Finally it signals completion to the lookup stage.

Parameters:
NUM_WAY, 2, number of ways; replace_way/v_ways/d_ways width
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)
TAG_WIDTH, 20, tag bits
INDEX_WIDTH, 8, set index bits; offset = $clog2(WORDS_PER_LINE)+2 bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
miss  in  1  lookup stage miss request, held until done
miss_addr  in  32  missing byte address, stable while miss high
v_ways  in  NUM_WAY  valid bits of addressed set
d_ways  in  NUM_WAY  dirty bits of addressed set
victim_tags  in  NUM_WAY*TAG_WIDTH  tags of addressed set, way i at [i*TAG_WIDTH +: TAG_WIDTH]
replace_way  in  NUM_WAY  one-hot victim way from replacement generator
replace_en  out  1  one-cycle pulse advancing the replacement generator
arr_rd_en  out  1  victim data-array read strobe
arr_word  out  $clog2(WORDS_PER_LINE)  word index for array read/write
arr_rd_data  in  32  victim word, valid cycle after arr_rd_en
arr_we  out  NUM_WAY  one-hot data-array word write enable
arr_wdata  out  32  refill word
tag_we  out  NUM_WAY  one-hot tag/valid/dirty write enable
tag_wdata  out  TAG_WIDTH  new tag (valid=1, dirty=0 written alongside)
wr_req  out  1  write-back request
wr_addr  out  32  line-aligned victim address {tag,index,0}
wr_data  out  32*WORDS_PER_LINE  victim line, word 0 in LSBs
wr_rdy  in  1  write-back accepted when wr_req&wr_rdy
rd_req  out  1  line read request
rd_addr  out  32  line-aligned miss address
rd_rdy  in  1  read accepted when rd_req&rd_rdy
ret_valid  in  1  refill word valid
ret_last  in  1  last refill word
ret_data  in  32  refill word
done  out  1  one-cycle pulse, line installed

Behaviour:
- Reset: state IDLE; all outputs 0; word counter 0; latched way 0.
- States: IDLE, VRD, WB, RREQ, REFILL, DONE.
- IDLE, miss=1: latch replace_way, miss_addr, victim tag. Pulse replace_en the same cycle. If the latched way has v&d set -> VRD, else -> RREQ.
- VRD:
  - Issue arr_rd_en for words 0..WORDS_PER_LINE-1 on consecutive cycles.
  - Capture arr_rd_data one cycle later into the line buffer.
  - Go to WB on the cycle the last word is captured (WORDS_PER_LINE+1 cycles in VRD).
- WB: wr_req=1 with wr_addr/wr_data stable until wr_rdy. On wr_req&wr_rdy -> RREQ; wr_req drops the next cycle.
- RREQ: rd_req=1, rd_addr stable until rd_rdy. On handshake -> REFILL, counter cleared.
- REFILL:
  - Each ret_valid: arr_we=latched way, arr_word=counter, arr_wdata=ret_data; counter increments, wrapping mod WORDS_PER_LINE.
  - On ret_valid&ret_last: additionally tag_we=latched way, tag_wdata=latched tag -> DONE.
  - ret_last terminates the refill even if the counter has not reached WORDS_PER_LINE-1.
- DONE: done=1 for one cycle -> IDLE. miss is not sampled in DONE; the lookup stage drops miss on the cycle after done.
- ret_valid outside REFILL: ignored, no array writes.
- replace_way not one-hot: latched as-is, undefined array effect; assertion fires in simulation.
- Reset in any state returns to IDLE next edge. Any in-flight handshake is abandoned; stray ret_valid is then ignored.
- Minimum clean-miss latency, miss to done with rd_rdy=1 and words every cycle: 2+WORDS_PER_LINE+1 cycles.

Optional Feature:
- Macro: CACHE_REFILL_FWD_EN.
- Defined: adds outputs fwd_valid (1) and fwd_data (32).
  - fwd_valid pulses in REFILL on the ret_valid beat whose counter equals miss_addr word offset; fwd_data=ret_data.
  - Lets the pipeline consume the load before done.
- Undefined: ports absent; no forwarding logic.

Test Plan:
- Clean miss:
  - Stimulus: v_ways=2'b01, replace_way=2'b10, miss_addr=0x0000_1234, rd_rdy=1, 4 words 0xA0..0xA3 back-to-back, ret_last on 4th.
  - Response: replace_en one pulse, rd_addr=0x0000_1230, arr_we=2'b10 words 0..3, tag_we=2'b10 with tag 0x00001, done 7 cycles after miss.
- Dirty victim:
  - Stimulus: v=d=2'b11, replace_way=2'b01, victim tag 0xABCDE, index 0x23, array words 0x11..0x44, wr_rdy held low 3 cycles.
  - Response: wr_req held 4 cycles, wr_addr=0xABCDE230, wr_data=0x00000044_00000033_00000022_00000011; rd_req only after wr handshake.
- Refill gaps: ret_valid on alternate cycles -> arr_we only on valid beats, arr_word 0,1,2,3 in order.
- Reset mid-REFILL after 2 beats:
  - Response: next cycle all outputs 0, state IDLE.
  - Then 2 stray ret_valid beats -> no arr_we/tag_we.
- Early ret_last on beat 2 -> tag_we on beat 2, done next cycle, counter reset for next miss.
- CACHE_REFILL_FWD_EN, miss_addr offset 0x8 (word 2) -> fwd_valid on 3rd beat only, fwd_data = that beat's data.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss-handling FSM: latches the victim way, writes back a dirty victim, refills the line, pulses done.
// Optional critical-word forwarding (fwd_valid/fwd_data) is built when CACHE_REFILL_FWD_EN is defined.
module cache_refill_ctrl #(
  parameter int NUM_WAY        = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_WIDTH      = 20,
  parameter int INDEX_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            miss,
  input  logic [31:0]                     miss_addr,
  input  logic [NUM_WAY-1:0]              v_ways,
  input  logic [NUM_WAY-1:0]              d_ways,
  input  logic [NUM_WAY*TAG_WIDTH-1:0]    victim_tags,
  input  logic [NUM_WAY-1:0]              replace_way,
  output logic                            replace_en,
  output logic                            arr_rd_en,
  output logic [$clog2(WORDS_PER_LINE)-1:0] arr_word,
  input  logic [31:0]                     arr_rd_data,
  output logic [NUM_WAY-1:0]              arr_we,
  output logic [31:0]                     arr_wdata,
  output logic [NUM_WAY-1:0]              tag_we,
  output logic [TAG_WIDTH-1:0]            tag_wdata,
  output logic                            wr_req,
  output logic [31:0]                     wr_addr,
  output logic [32*WORDS_PER_LINE-1:0]    wr_data,
  input  logic                            wr_rdy,
  output logic                            rd_req,
  output logic [31:0]                     rd_addr,
  input  logic                            rd_rdy,
  input  logic                            ret_valid,
  input  logic                            ret_last,
  input  logic [31:0]                     ret_data,
  output logic                            done
`ifdef CACHE_REFILL_FWD_EN
  ,
  output logic                            fwd_valid,
  output logic [31:0]                     fwd_data
`endif
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WORD_W + 2;
  localparam logic [WORD_W:0] CNT_END = (WORD_W+1)'(WORDS_PER_LINE);

  typedef enum logic [2:0] {IDLE, VRD, WB, RREQ, REFILL, DONE} state_t;

  state_t                        state_q, state_d;
  logic [WORD_W:0]               cnt_q, cnt_d;
  logic [NUM_WAY-1:0]            way_q;
  logic [31:0]                   line_addr_q;
  logic [TAG_WIDTH-1:0]          vtag_q;
  logic [32*WORDS_PER_LINE-1:0]  line_buf_q;
  logic [TAG_WIDTH-1:0]          victim_tag_sel;
  logic                          victim_dirty;
  logic                          capture;
  logic [WORD_W-1:0]             cap_idx;
  logic                          unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  always_comb begin
    victim_tag_sel = '0;
    for (int i = 0; i < NUM_WAY; i++)
      if (replace_way[i]) victim_tag_sel |= victim_tags[i*TAG_WIDTH +: TAG_WIDTH];
  end

  assign victim_dirty = |(replace_way & v_ways & d_ways);

  // In VRD, cycle k reads word k and captures word k-1 returned from the previous read.
  assign cap_idx = cnt_q[WORD_W-1:0] - 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    replace_en = 1'b0;
    arr_rd_en  = 1'b0;
    arr_word   = '0;
    arr_we     = '0;
    tag_we     = '0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          replace_en = 1'b1;
          cnt_d      = '0;
          state_d    = victim_dirty ? VRD : RREQ;
        end
      end
      VRD: begin
        if (cnt_q != CNT_END) begin
          arr_rd_en = 1'b1;
          arr_word  = cnt_q[WORD_W-1:0];
        end
        capture = (cnt_q != '0);
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        wr_req = 1'b1;
        if (wr_rdy) state_d = RREQ;
      end
      RREQ: begin
        rd_req = 1'b1;
        if (rd_rdy) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (ret_valid) begin
          arr_we   = way_q;
          arr_word = cnt_q[WORD_W-1:0];
          cnt_d    = {1'b0, cnt_q[WORD_W-1:0] + 1'b1};
          if (ret_last) begin
            tag_we  = way_q;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      way_q       <= '0;
      line_addr_q <= '0;
      vtag_q      <= '0;
      // NOTE: the line buffer is reset as well so wr_data never exposes stale victim data after reset.
      line_buf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && miss) begin
        way_q       <= replace_way;
        line_addr_q <= {miss_addr[31:OFF_W], {OFF_W{1'b0}}};
        vtag_q      <= victim_tag_sel;
      end
      if (capture) line_buf_q[32*cap_idx +: 32] <= arr_rd_data;
    end
  end

  assign arr_wdata = (state_q == REFILL && ret_valid) ? ret_data : '0;
  assign tag_wdata = line_addr_q[31 -: TAG_WIDTH];
  assign rd_addr   = line_addr_q;
  assign wr_addr   = {vtag_q, line_addr_q[OFF_W +: INDEX_WIDTH], {OFF_W{1'b0}}};
  assign wr_data   = line_buf_q;

`ifdef CACHE_REFILL_FWD_EN
  logic [WORD_W-1:0] word_off_q;

  always_ff @(posedge clk) begin
    if (reset)                          word_off_q <= '0;
    else if (state_q == IDLE && miss)   word_off_q <= miss_addr[2 +: WORD_W];
  end

  assign fwd_valid = (state_q == REFILL) && ret_valid && (cnt_q[WORD_W-1:0] == word_off_q);
  assign fwd_data  = fwd_valid ? ret_data : '0;
`endif

`ifndef SYNTHESIS
  // A non-one-hot victim has no defined array effect; flag it where it is latched.
  always @(posedge clk) begin
    if (!reset && state_q == IDLE && miss)
      assert ($onehot(replace_way));
  end
`endif

endmodule
